// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if
// Groups the interrupt controller's signals toward the IO memory and the CPU
// into one bundle.
//
// Signals:
//   io_intr    : interrupt request level from the IO memory
//   intr_en    : CPU interrupt-enable flag
//   cpu_inta   : CPU takes the interrupt (1-clock pulse)
//   reti       : CPU return-from-interrupt (1-clock pulse)
//   cpu_intr   : interrupt request to the CPU
//   isr_addr   : ISR entry address (32 bits)
//   intr_ack   : acknowledge handshake back to the IO memory
//   in_isr     : high while the ISR is executing
//   intr_count : number of interrupts taken (8 bits, wraps)
//
// Modports:
//   master : the CPU/IO side, which drives the request and handshake inputs
//   slave  : the controller, which consumes them and drives the status outputs
interface intr_ctrl_if;
    logic        io_intr;
    logic        intr_en;
    logic        cpu_inta;
    logic        reti;
    logic        cpu_intr;
    logic [31:0] isr_addr;
    logic        intr_ack;
    logic        in_isr;
    logic [7:0]  intr_count;

    modport master (
        output io_intr, intr_en, cpu_inta, reti,
        input  cpu_intr, isr_addr, intr_ack, in_isr, intr_count
    );

    modport slave (
        input  io_intr, intr_en, cpu_inta, reti,
        output cpu_intr, isr_addr, intr_ack, in_isr, intr_count
    );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl
// Single-level interrupt controller between an IO memory and a CPU.
// A rising edge on io_intr latches a pending request. When the CPU has
// interrupts enabled, the request is raised on cpu_intr. Once the CPU takes
// it with cpu_inta, the controller acknowledges the IO memory for ACK_CYCLES
// clocks. It then reports in_isr until the CPU signals reti.
//
// Parameters:
//   ISR_VECTOR : ISR entry address presented on isr_addr
//   ACK_CYCLES : clocks that intr_ack stays high (legal range 1..15)
//
// Ports:
//   clk : system clock; all state changes on its rising edge
//   rst : asynchronous, active-high reset
//   bus : intr_ctrl_if.slave (io_intr, intr_en, cpu_inta, reti in;
//         cpu_intr, isr_addr, intr_ack, in_isr, intr_count out)
//
// Build option:
//   INTR_SYNC_EN : when defined, io_intr passes through a two-flop
//                  synchronizer before edge detection. This adds two clocks
//                  of request latency.
module intr_ctrl #(
    parameter logic [31:0] ISR_VECTOR = 32'h0000_03FC,
    parameter int          ACK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    intr_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        ISR  = 2'd3
    } state_t;

    localparam logic [3:0] ACK_LAST = 4'(ACK_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic       sample_cur;
    logic       sample_prev;
    logic       rise;
    logic       pending;
    logic       take;
    logic       ack_done;
    logic [3:0] ack_cnt;
    logic [7:0] count;

`ifdef INTR_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer for the asynchronous request level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.io_intr;
            sync2 <= sync1;
        end
    end

    assign sample_cur = sync2;
`else
    assign sample_cur = bus.io_intr;
`endif

    // Previous sample, used for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_prev <= 1'b0;
        end else begin
            sample_prev <= sample_cur;
        end
    end

    assign rise     = sample_cur & ~sample_prev;
    assign take     = (state == REQ) && bus.cpu_inta;
    assign ack_done = (state == ACK) && (ack_cnt == ACK_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. cpu_inta wins over a simultaneous drop of intr_en.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (pending && bus.intr_en) next_state = REQ;
            REQ: begin
                if (bus.cpu_inta)      next_state = ACK;
                else if (!bus.intr_en) next_state = IDLE;
            end
            ACK:  if (ack_done) next_state = ISR;
            ISR:  if (bus.reti) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pending flag, acknowledge timer and taken-interrupt counter.
    // A fresh edge overrides the clear from cpu_inta, so a request that
    // arrives while the CPU is taking the previous one is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            ack_cnt <= 4'd0;
            count   <= 8'd0;
        end else begin
            pending <= rise | (pending & ~take);
            if ((state == ACK) && !ack_done) begin
                ack_cnt <= ack_cnt + 4'd1;
            end else begin
                ack_cnt <= 4'd0;
            end
            if (take) begin
                count <= count + 8'd1;
            end
        end
    end

    assign bus.cpu_intr   = (state == REQ);
    assign bus.intr_ack   = (state == ACK);
    assign bus.in_isr     = (state == ISR);
    assign bus.intr_count = count;
    assign bus.isr_addr   = ISR_VECTOR;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl
// Self-checking bench for intr_ctrl. Directed scenarios and a randomized
// phase are checked every clock against a behavioural model of the
// controller's request/acknowledge/service protocol.
module tb_intr_ctrl;

    localparam logic [31:0] VEC   = 32'h0000_03FC;
    localparam int          ACK_N = 2;
`ifdef INTR_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic clk;
    logic rst;
    intr_ctrl_if bus();

    intr_ctrl #(.ISR_VECTOR(VEC), .ACK_CYCLES(ACK_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    bit       m_req;
    bit       m_isr;
    bit       m_pending;
    int       m_ack_left;
    int       m_count;
    bit [3:0] m_hist;

    function automatic void modelReset();
        m_req      = 1'b0;
        m_isr      = 1'b0;
        m_pending  = 1'b0;
        m_ack_left = 0;
        m_count    = 0;
        m_hist     = 4'b0;
    endfunction

    // One rising clock edge of the controller protocol
    function automatic void modelStep(bit io, bit en, bit inta, bit rt);
        bit rise;
        bit take;
        m_hist = {m_hist[2:0], io};
        rise = m_hist[SYNC_DLY] && !m_hist[SYNC_DLY+1];
        take = 1'b0;
        if (m_req) begin
            if (inta) begin
                m_req      = 1'b0;
                m_ack_left = ACK_N;
                m_count    = (m_count + 1) % 256;
                take       = 1'b1;
            end else if (!en) begin
                m_req = 1'b0;
            end
        end else if (m_ack_left > 0) begin
            m_ack_left = m_ack_left - 1;
            if (m_ack_left == 0) m_isr = 1'b1;
        end else if (m_isr) begin
            if (rt) m_isr = 1'b0;
        end else if (m_pending && en) begin
            m_req = 1'b1;
        end
        m_pending = rise || (m_pending && !take);
    endfunction

    task automatic expectBit(string tag, logic observed, logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(string tag);
        expectBit({tag, ".cpu_intr"}, bus.cpu_intr, m_req);
        expectBit({tag, ".intr_ack"}, bus.intr_ack, 1'(m_ack_left > 0));
        expectBit({tag, ".in_isr"}, bus.in_isr, m_isr);
        compared++;
        assert (bus.intr_count === 8'(m_count)) else begin
            mismatched++;
            $error("[TB] FAIL %s.intr_count observed=%0d expected=%0d", tag, bus.intr_count, m_count);
        end
        compared++;
        assert (bus.isr_addr === VEC) else begin
            mismatched++;
            $error("[TB] FAIL %s.isr_addr observed=%h expected=%h", tag, bus.isr_addr, VEC);
        end
    endtask

    task automatic applyStimulus(bit io, bit en, bit inta, bit rt, string tag);
        @(negedge clk);
        bus.io_intr  = io;
        bus.intr_en  = en;
        bus.cpu_inta = inta;
        bus.reti     = rt;
        @(posedge clk);
        modelStep(io, en, inta, rt);
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset raised between clock edges, checked before any edge
    task automatic pulseReset(string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput({tag, ".async"});
        bus.io_intr  = 1'b0;
        bus.intr_en  = 1'b0;
        bus.cpu_inta = 1'b0;
        bus.reti     = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, ".held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic serviceOne();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "svc.low");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "svc.rise");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, m_req, m_isr, "svc.run");
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.io_intr  = 1'b0;
        bus.intr_en  = 1'b0;
        bus.cpu_inta = 1'b0;
        bus.reti     = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic service: request latency, acknowledge length, ISR entry
        for (int i = 0; i <= SYNC_DLY + 1; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "basic.lat");
            expectBit("basic.cpu_intr_edge", bus.cpu_intr, 1'(i == SYNC_DLY + 1));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "basic.req_hold");
        expectBit("basic.req_hold", bus.cpu_intr, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "basic.inta");
        expectBit("basic.ack1", bus.intr_ack, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "basic.ack2");
        expectBit("basic.ack2", bus.intr_ack, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "basic.isr");
        expectBit("basic.ack_off", bus.intr_ack, 1'b0);
        expectBit("basic.in_isr", bus.in_isr, 1'b1);
        compared++;
        assert (bus.intr_count === 8'd1) else begin
            mismatched++;
            $error("[TB] FAIL basic.count observed=%0d expected=1", bus.intr_count);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "basic.stray_inta");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "basic.reti");
        expectBit("basic.idle", bus.in_isr, 1'b0);

        // Request held off by intr_en, then withdrawn and re-raised
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "en.low_stray_reti");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "en.rise");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "en.wait");
        expectBit("en.no_req", bus.cpu_intr, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "en.enable");
        expectBit("en.req", bus.cpu_intr, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "en.drop");
        expectBit("en.dropped", bus.cpu_intr, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "en.reenable");
        expectBit("en.kept", bus.cpu_intr, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "en.inta_prio");
        expectBit("en.inta_prio", bus.intr_ack, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "en.ack");

        // Edges during ISR collapse into one further service
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "isr.edge1");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "isr.low");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "isr.edge2");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "isr.wait");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "isr.reti");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "isr.rereq");
        expectBit("isr.rereq", bus.cpu_intr, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "isr.inta");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "isr.run");
        // reti and a fresh edge in the same cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "isr.reti_edge");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, m_req, m_isr, "isr.tail");

        // Reset in the first acknowledge cycle discards everything
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "rst.low");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "rst.rise");
        for (int i = 0; i < SYNC_DLY + 1; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "rst.wait");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "rst.inta");
        expectBit("rst.in_ack", bus.intr_ack, 1'b1);
        pulseReset("rst.mid_ack");
        expectBit("rst.ack_dropped", bus.intr_ack, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "rst.quiet");
        expectBit("rst.no_service", bus.cpu_intr, 1'b0);

        // 256 services wrap the counter back to zero
        for (int n = 0; n < 256; n++) serviceOne();
        compared++;
        assert (bus.intr_count === 8'd0) else begin
            mismatched++;
            $error("[TB] FAIL wrap.count observed=%0d expected=0", bus.intr_count);
        end

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), "rand");
            if ($urandom_range(0, 299) == 0) pulseReset("rand.rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
